bf_io_bridge: RTL and testbench
===============================

// Module: bf_io_bridge
// PURPOSE
//  Responder side of the BF core's byte I/O streams. Buffers host bytes into an input FIFO
//  served to the core (in_val/in_valid/in_reading). Captures core output (out_val/out_enable)
//  into an output FIFO drained by the host over valid/ready. Generates the core's enable so
//  no output byte is ever lost.
// PARAMETERS
//  IN_DEPTH   8  input FIFO entries; power of two, >= 2
//  OUT_DEPTH  8  output FIFO entries; power of two, >= 2
// PORTS
//  clock           in   1     single clock, rising edge
//  reset           in   1     asynchronous, active-high
//  run             in   1     top-level run request
//  core_enable     out  1     drives the BF core's enable
//  in_val          out  8     head of input FIFO, to core
//  in_valid        out  1     input FIFO non-empty, to core
//  in_reading      in   1     core consumes in_val this edge
//  out_val         in   8     byte from core
//  out_enable      in   1     core emits out_val this edge
//  halted          in   1     core halted flag
//  host_in_data    in   8     host byte to core
//  host_in_valid   in   1     host_in_data valid
//  host_in_ready   out  1     input FIFO can accept
//  host_out_data   out  8     head of output FIFO
//  host_out_valid  out  1     output FIFO non-empty
//  host_out_ready  in   1     host takes host_out_data
//  in_level        out  $clog2(IN_DEPTH)+1   input FIFO occupancy
//  out_level       out  $clog2(OUT_DEPTH)+1  output FIFO occupancy
//  done            out  1     halted && output FIFO empty
// BEHAVIOUR
//  - Reset (async): both FIFOs empty, pointers 0.
//    - Outputs: in_valid=0, host_in_ready=1, host_out_valid=0, levels=0.
//    - Storage is not cleared; its contents are don't-care.
//    - A reset mid-operation discards all queued bytes.
//  - core_enable = run && !out_full (combinational). No bypass: a host pop in the same cycle
//    does not raise core_enable; it rises the cycle after.
//  - Input FIFO (first-word fall-through):
//    - in_val = head entry; in_valid = !in_empty.
//    - Push on host_in_valid && host_in_ready; host_in_ready = !in_full.
//    - Pop on in_reading && in_valid && core_enable. The core asserts in_reading even while
//      disabled, so the core_enable qualification is mandatory.
//    - Full with pop pending: the push is still refused that cycle (ready ignores pop).
//  - Output FIFO (first-word fall-through):
//    - Push on out_enable && core_enable.
//    - host_out_data = head entry; host_out_valid = !out_empty.
//    - Pop on host_out_valid && host_out_ready.
//    - Simultaneous push and pop when non-empty and non-full: occupancy unchanged, order kept.
//  - Latency:
//    - Host byte accepted at edge N: in_valid/in_val are valid after edge N.
//    - Core '.' at edge N: host_out_valid/host_out_data are valid after edge N.
//  - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    - full: MSBs differ, lower bits equal. empty: pointers equal.
//    - level = wr_ptr - rd_ptr (modular).
//  - done is combinational from halted and out_empty; bytes still queued in the input FIFO
//    at halt are kept, not flushed.
//  - All byte arithmetic is 8-bit; no data transformation.
// STRUCTURE
//  - bf_pkg: typedef logic [7:0] byte_t; localparam BYTE_W = 8.
//  - Sub-module bf_byte_fifo #(DEPTH), instantiated twice.
//    - Ports: clock, reset, push, push_data, pop, head, empty, full, level.
//    - Elaboration-time check that DEPTH is a power of two and >= 2.
//  - Top level holds only the qualification logic above.
// TESTING
//  1 Reset release, run=1 -> host_in_ready=1, in_valid=0, host_out_valid=0, levels 0, core_enable=1.
//  2 Host pushes 0x41,0x42; core in_reading for 2 enabled cycles -> in_val 0x41 then 0x42,
//    then in_valid=0. in_reading with run=0 -> no pop, in_level unchanged.
//  3 host_out_ready=0; 8 out_enable bytes 0x01..0x08 -> out_level=8, core_enable=0, 9th
//    out_enable ignored. Raise ready -> 0x01..0x08 in order; core_enable=1 the cycle after first pop.
//  4 Input full (8 bytes), push + pop same cycle -> pop occurs, push refused, in_level=7;
//    next cycle push accepted.
//  5 Stream 40 bytes through each FIFO with pseudo-random valid/ready -> exact order preserved
//    across pointer wrap; levels never exceed DEPTH.
//  6 Queue 3 bytes per FIFO, assert reset mid-stream -> all empty immediately.
//    halted=1 with out empty -> done=1; halted=1 with out_level=2 -> done=0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared byte type and elaboration helpers for the BF core I/O bridge.
package bf_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/bf_byte_fifo.sv
// First-word fall-through byte FIFO with extra-MSB pointers for full/empty detection.
module bf_byte_fifo
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    output byte_t                    head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("bf_byte_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    byte_t       mem_q [DEPTH];
    logic        push_en;
    logic        pop_en;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
        head     = mem_q[rd_ptr_q[AW-1:0]];
        level    = wr_ptr_q - rd_ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bf_io_bridge.sv
// Responder for the BF core byte streams: host->core input FIFO, core->host output FIFO,
// and a core enable that stalls the core whenever an output byte could not be stored.
module bf_io_bridge
    import bf_pkg::*;
#(
    parameter int unsigned IN_DEPTH  = 8,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    output logic                         core_enable,
    output byte_t                        in_val,
    output logic                         in_valid,
    input  logic                         in_reading,
    input  byte_t                        out_val,
    input  logic                         out_enable,
    input  logic                         halted,
    input  byte_t                        host_in_data,
    input  logic                         host_in_valid,
    output logic                         host_in_ready,
    output byte_t                        host_out_data,
    output logic                         host_out_valid,
    input  logic                         host_out_ready,
    output logic [$clog2(IN_DEPTH):0]    in_level,
    output logic [$clog2(OUT_DEPTH):0]   out_level,
    output logic                         done
);

    logic in_empty, in_full, in_push, in_pop;
    logic out_empty, out_full, out_push, out_pop;

    always_comb begin
        // No bypass from a same-cycle host pop: the enable follows registered fullness only.
        core_enable    = run && !out_full;
        in_valid       = !in_empty;
        host_in_ready  = !in_full;
        in_push        = host_in_valid && host_in_ready;
        // The core drives in_reading even while stalled, so gate it with the enable.
        in_pop         = in_reading && in_valid && core_enable;
        out_push       = out_enable && core_enable;
        host_out_valid = !out_empty;
        out_pop        = host_out_valid && host_out_ready;
        done           = halted && out_empty;
    end

    bf_byte_fifo #(
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_push),
        .push_data (host_in_data),
        .pop       (in_pop),
        .head      (in_val),
        .empty     (in_empty),
        .full      (in_full),
        .level     (in_level)
    );

    bf_byte_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (out_push),
        .push_data (out_val),
        .pop       (out_pop),
        .head      (host_out_data),
        .empty     (out_empty),
        .full      (out_full),
        .level     (out_level)
    );

endmodule

// File: tb/tb_bf_io_bridge.sv
// Directed checks of the BF I/O bridge FIFOs, core enable gating, reset and done.
module tb_bf_io_bridge;

    logic       clock;
    logic       reset;
    logic       run;
    logic       core_enable;
    logic [7:0] in_val;
    logic       in_valid;
    logic       in_reading;
    logic [7:0] out_val;
    logic       out_enable;
    logic       halted;
    logic [7:0] host_in_data;
    logic       host_in_valid;
    logic       host_in_ready;
    logic [7:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready;
    logic [3:0] in_level;
    logic [3:0] out_level;
    logic       done;

    int checks   = 0;
    int failures = 0;

    bf_io_bridge #(
        .IN_DEPTH  (8),
        .OUT_DEPTH (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .core_enable    (core_enable),
        .in_val         (in_val),
        .in_valid       (in_valid),
        .in_reading     (in_reading),
        .out_val        (out_val),
        .out_enable     (out_enable),
        .halted         (halted),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .in_level       (in_level),
        .out_level      (out_level),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int in_cnt, out_cnt, in_tx, in_rx, out_tx, out_rx, cyc;
        logic exp_ready, exp_cen;

        reset          = 1'b1;
        run            = 1'b1;
        in_reading     = 1'b0;
        out_val        = 8'h00;
        out_enable     = 1'b0;
        halted         = 1'b0;
        host_in_data   = 8'h00;
        host_in_valid  = 1'b0;
        host_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1: reset state
        check("rst_in_ready", 32'(host_in_ready), 1);
        check("rst_in_valid", 32'(in_valid), 0);
        check("rst_out_valid", 32'(host_out_valid), 0);
        check("rst_in_level", 32'(in_level), 0);
        check("rst_out_level", 32'(out_level), 0);
        check("rst_core_en", 32'(core_enable), 1);
        check("rst_done", 32'(done), 0);

        // 2: host pushes two bytes, disabled read ignored, enabled reads pop in order
        host_in_valid = 1'b1;
        host_in_data  = 8'h41;
        tick();
        check("in_first_latency", 32'(in_val), 32'h41);
        host_in_data = 8'h42;
        tick();
        host_in_valid = 1'b0;
        #1;
        check("in_level_2", 32'(in_level), 2);
        check("in_head_41", 32'(in_val), 32'h41);
        run        = 1'b0;
        in_reading = 1'b1;
        #1;
        check("run0_core_en", 32'(core_enable), 0);
        tick();
        check("run0_no_pop_level", 32'(in_level), 2);
        check("run0_no_pop_head", 32'(in_val), 32'h41);
        run = 1'b1;
        tick();
        check("pop1_head_42", 32'(in_val), 32'h42);
        check("pop1_level", 32'(in_level), 1);
        tick();
        check("pop2_in_valid", 32'(in_valid), 0);
        check("pop2_level", 32'(in_level), 0);
        in_reading = 1'b0;

        // 3: output FIFO fills, stalls the core, then drains in order
        host_out_ready = 1'b0;
        out_enable     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            out_val = 8'(i);
            tick();
            if (i == 1) check("out_first_latency", 32'(host_out_data), 1);
        end
        check("out_full_level", 32'(out_level), 8);
        check("out_full_core_en", 32'(core_enable), 0);
        out_val = 8'h09;
        tick();
        check("out_9th_ignored", 32'(out_level), 8);
        out_enable     = 1'b0;
        host_out_ready = 1'b1;
        #1;
        check("no_bypass_core_en", 32'(core_enable), 0);
        check("out_head_1", 32'(host_out_data), 1);
        tick();
        check("core_en_after_pop", 32'(core_enable), 1);
        check("out_level_7", 32'(out_level), 7);
        for (int j = 2; j <= 8; j++) begin
            check("out_drain_order", 32'(host_out_data), 32'(j));
            tick();
        end
        check("out_drained_valid", 32'(host_out_valid), 0);
        check("out_drained_level", 32'(out_level), 0);
        host_out_ready = 1'b0;

        // 4: full input FIFO with push and pop in the same cycle
        host_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_in_data = 8'(8'h10 + i);
            tick();
        end
        check("in_full_level", 32'(in_level), 8);
        check("in_full_ready", 32'(host_in_ready), 0);
        host_in_data = 8'hAA;
        in_reading   = 1'b1;
        tick();
        check("full_pushpop_level", 32'(in_level), 7);
        check("full_pushpop_head", 32'(in_val), 32'h11);
        in_reading = 1'b0;
        tick();
        check("push_after_level", 32'(in_level), 8);
        host_in_valid = 1'b0;
        in_reading    = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check("in_drain_order", 32'(in_val), 32'(8'h10 + i));
            tick();
        end
        check("in_drain_last", 32'(in_val), 32'hAA);
        tick();
        check("in_drained_valid", 32'(in_valid), 0);
        in_reading = 1'b0;

        // 5: 40 bytes through each FIFO with random handshakes, against a level model
        in_cnt = 0; out_cnt = 0; in_tx = 0; in_rx = 0; out_tx = 0; out_rx = 0; cyc = 0;
        while ((in_rx < 40 || out_rx < 40) && cyc < 3000) begin
            host_in_valid  = (in_tx < 40) && ($urandom_range(0, 1) == 1);
            host_in_data   = 8'(8'h80 + in_tx);
            in_reading     = ($urandom_range(0, 2) == 0);
            out_enable     = (out_tx < 40) && ($urandom_range(0, 1) == 1);
            out_val        = 8'(8'hC0 + out_tx);
            host_out_ready = ($urandom_range(0, 2) == 0);
            #1;
            exp_ready = (in_cnt < 8);
            exp_cen   = (out_cnt < 8);
            check("s_in_ready", 32'(host_in_ready), 32'(exp_ready));
            check("s_core_en", 32'(core_enable), 32'(exp_cen));
            check("s_in_level", 32'(in_level), 32'(in_cnt));
            check("s_out_level", 32'(out_level), 32'(out_cnt));
            if (in_reading && in_cnt > 0 && exp_cen) begin
                check("s_in_data", 32'(in_val), 32'(8'(8'h80 + in_rx)));
                in_rx++;
                in_cnt--;
            end
            if (host_in_valid && exp_ready) begin
                in_tx++;
                in_cnt++;
            end
            if (host_out_ready && out_cnt > 0) begin
                check("s_out_data", 32'(host_out_data), 32'(8'(8'hC0 + out_rx)));
                out_rx++;
                out_cnt--;
            end
            if (out_enable && exp_cen) begin
                out_tx++;
                out_cnt++;
            end
            tick();
            cyc++;
        end
        check("s_all_received", 32'(in_rx + out_rx), 80);
        host_in_valid  = 1'b0;
        in_reading     = 1'b0;
        out_enable     = 1'b0;
        host_out_ready = 1'b0;

        // 6: reset mid-stream discards everything, then done behaviour
        host_in_valid = 1'b1;
        out_enable    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_data = 8'(8'h50 + i);
            out_val      = 8'(8'h60 + i);
            tick();
        end
        host_in_valid = 1'b0;
        out_enable    = 1'b0;
        #1;
        check("pre_rst_in_level", 32'(in_level), 3);
        check("pre_rst_out_level", 32'(out_level), 3);
        reset = 1'b1;
        #1;
        check("mid_rst_in_level", 32'(in_level), 0);
        check("mid_rst_out_level", 32'(out_level), 0);
        check("mid_rst_in_valid", 32'(in_valid), 0);
        check("mid_rst_out_valid", 32'(host_out_valid), 0);
        check("mid_rst_in_ready", 32'(host_in_ready), 1);
        tick();
        reset  = 1'b0;
        halted = 1'b1;
        #1;
        check("done_empty", 32'(done), 1);
        out_enable = 1'b1;
        out_val    = 8'h77;
        tick();
        out_val = 8'h78;
        tick();
        out_enable = 1'b0;
        #1;
        check("done_level_2", 32'(out_level), 2);
        check("done_not_empty", 32'(done), 0);
        check("post_rst_head", 32'(host_out_data), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
